// File: rtl/control_mux_stream_n_if.sv
// Control/status bundle for control_mux_stream_n: run request, step gating and per-channel mux resets.
// Status signals round_idx/start_err exist only when CTRL_MUX_STREAM_STATUS_EN is defined.
interface control_mux_stream_n_if #(
    parameter int NUM_CH = 4,
    parameter int RW     = 8
);
    logic              start;
    logic              flush;
    logic              en;
    logic [RW-1:0]     num_rounds;
    logic [NUM_CH-1:0] mux_reset;
    logic              busy;
    logic              done;
`ifdef CTRL_MUX_STREAM_STATUS_EN
    logic [RW-1:0]     round_idx;
    logic              start_err;

    modport master (
        output start, flush, en, num_rounds,
        input  mux_reset, busy, done, round_idx, start_err
    );
    modport slave (
        input  start, flush, en, num_rounds,
        output mux_reset, busy, done, round_idx, start_err
    );
`else
    modport master (
        output start, flush, en, num_rounds,
        input  mux_reset, busy, done
    );
    modport slave (
        input  start, flush, en, num_rounds,
        output mux_reset, busy, done
    );
`endif
endinterface

// File: rtl/control_mux_stream_n.sv
// Staggered N-channel mux-reset release sequencer, repeated for num_rounds (optional status: CTRL_MUX_STREAM_STATUS_EN).
// Latency: start sampled at edge T -> busy and mux_reset[0]=0 visible after T; mux_reset is a pure decode of registered state.
// Backpressure: en=0 freezes the step counter and outputs; flush aborts to IDLE and outranks start/en; no start queuing.
module control_mux_stream_n #(
    parameter int NUM_CH  = 4,
    parameter int WINDOW  = 2,
    parameter int STAGGER = 1,
    parameter int RW      = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    control_mux_stream_n_if.slave  bus
);
    localparam int LAST = (NUM_CH - 1) * STAGGER + WINDOW;
    localparam int CW   = $clog2(LAST + 1);
    localparam logic [CW-1:0] CNT_END = CW'(LAST - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [RW-1:0]     round_q, round_d;
    logic [RW-1:0]     rounds_q, rounds_d;
    logic [NUM_CH-1:0] mux_reset_d;
    logic              start_ok;

    assign start_ok = (state_q == S_IDLE) && bus.start && !bus.flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            round_q  <= '0;
            rounds_q <= RW'(1);
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            round_q  <= round_d;
            rounds_q <= rounds_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        round_d  = round_q;
        rounds_d = rounds_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d  = S_RUN;
                    cnt_d    = '0;
                    round_d  = '0;
                    rounds_d = (bus.num_rounds == '0) ? RW'(1) : bus.num_rounds;
                end
            end
            S_RUN: begin
                if (bus.en) begin
                    if (cnt_q == CNT_END) begin
                        cnt_d = '0;
                        // Last step of the last round ends the run; otherwise wrap straight into the next round.
                        if (round_q == rounds_q - RW'(1)) begin
                            state_d = S_DONE;
                            round_d = '0;
                        end else begin
                            round_d = round_q + RW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (bus.flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            round_d = '0;
        end
    end

    always_comb begin
        mux_reset_d = '1;
        if (state_q == S_RUN) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (int'(cnt_q) >= i * STAGGER && int'(cnt_q) < i * STAGGER + WINDOW) begin
                    mux_reset_d[i] = 1'b0;
                end
            end
        end
    end

    assign bus.mux_reset = mux_reset_d;
    assign bus.busy      = (state_q == S_RUN);
    assign bus.done      = (state_q == S_DONE);

`ifdef CTRL_MUX_STREAM_STATUS_EN
    logic start_err_q;

    // Sticky flag for starts that arrive while a run is still in progress or completing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            start_err_q <= 1'b0;
        end else if (start_ok) begin
            start_err_q <= 1'b0;
        end else if (bus.start && (state_q != S_IDLE)) begin
            start_err_q <= 1'b1;
        end
    end

    assign bus.round_idx = (state_q == S_RUN) ? round_q : '0;
    assign bus.start_err = start_err_q;
`endif
endmodule

// File: tb/tb_control_mux_stream_n.sv
// Directed bench for control_mux_stream_n: a 4-channel default instance plus a 2-channel instance.
module tb_control_mux_stream_n;
    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    control_mux_stream_n_if #(.NUM_CH(4), .RW(8)) b1 ();
    control_mux_stream_n_if #(.NUM_CH(2), .RW(8)) b2 ();

    control_mux_stream_n #(.NUM_CH(4), .WINDOW(2), .STAGGER(1), .RW(8)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(b1.slave)
    );
    control_mux_stream_n #(.NUM_CH(2), .WINDOW(2), .STAGGER(1), .RW(8)) u2 (
        .clk(clk), .rst_n(rst_n), .bus(b2.slave)
    );

    logic [3:0] pat [5];
    logic [3:0] t2m [9];
    logic [1:0] p2  [3];

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        pat[0] = 4'b1110; pat[1] = 4'b1100; pat[2] = 4'b1001; pat[3] = 4'b0011; pat[4] = 4'b0111;
        t2m[0] = 4'b1110; t2m[1] = 4'b1100; t2m[2] = 4'b1001; t2m[3] = 4'b1001; t2m[4] = 4'b1001;
        t2m[5] = 4'b1001; t2m[6] = 4'b0011; t2m[7] = 4'b0111; t2m[8] = 4'b1111;
        p2[0] = 2'b10; p2[1] = 2'b00; p2[2] = 2'b01;

        rst_n = 1'b0;
        b1.start = 1'b0; b1.flush = 1'b0; b1.en = 1'b1; b1.num_rounds = 8'd1;
        b2.start = 1'b0; b2.flush = 1'b0; b2.en = 1'b1; b2.num_rounds = 8'd2;
        tick(); tick();
        rst_n = 1'b1;
        chk("rst_mux", b1.mux_reset, 4'b1111);
        chk("rst_busy", b1.busy, 1'b0);
        chk("rst_done", b1.done, 1'b0);
        chk("rst_mux2", b2.mux_reset, 2'b11);

        // Single round, en held high
        b1.start = 1'b1; tick(); b1.start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t1_mux%0d", k), b1.mux_reset, pat[k]);
            chk($sformatf("t1_busy%0d", k), b1.busy, 1'b1);
            chk($sformatf("t1_done%0d", k), b1.done, 1'b0);
            tick();
        end
        chk("t1_done", b1.done, 1'b1);
        chk("t1_done_mux", b1.mux_reset, 4'b1111);
        chk("t1_done_busy", b1.busy, 1'b0);
        tick();
        chk("t1_idle_done", b1.done, 1'b0);

        // en low for three steps while cnt=2
        b1.start = 1'b1; tick(); b1.start = 1'b0;
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("t2_mux%0d", k), b1.mux_reset, t2m[k]);
            chk($sformatf("t2_busy%0d", k), b1.busy, (k < 8) ? 1'b1 : 1'b0);
            chk($sformatf("t2_done%0d", k), b1.done, (k == 8) ? 1'b1 : 1'b0);
            b1.en = (k >= 2 && k <= 4) ? 1'b0 : 1'b1;
            tick();
        end
        chk("t2_idle_done", b1.done, 1'b0);

        // Three rounds back to back, then num_rounds=0 acting as one round
        b1.num_rounds = 8'd3;
        b1.start = 1'b1; tick(); b1.start = 1'b0;
        for (int k = 0; k < 15; k++) begin
            chk($sformatf("t3_mux%0d", k), b1.mux_reset, pat[k % 5]);
            chk($sformatf("t3_busy%0d", k), b1.busy, 1'b1);
            chk($sformatf("t3_done%0d", k), b1.done, 1'b0);
            tick();
        end
        chk("t3_done", b1.done, 1'b1);
        tick();
        chk("t3_idle_done", b1.done, 1'b0);
        chk("t3_idle_busy", b1.busy, 1'b0);

        b1.num_rounds = 8'd0;
        b1.start = 1'b1; tick(); b1.start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t3z_mux%0d", k), b1.mux_reset, pat[k]);
            chk($sformatf("t3z_busy%0d", k), b1.busy, 1'b1);
            tick();
        end
        chk("t3z_done", b1.done, 1'b1);
        tick();

        // Flush at cnt=3 of round 1, then start together with flush in IDLE
        b1.num_rounds = 8'd3;
        b1.start = 1'b1; tick(); b1.start = 1'b0;
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("t4_mux%0d", k), b1.mux_reset, pat[k % 5]);
            if (k == 8) b1.flush = 1'b1;
            tick();
        end
        chk("t4_fl_mux", b1.mux_reset, 4'b1111);
        chk("t4_fl_busy", b1.busy, 1'b0);
        chk("t4_fl_done", b1.done, 1'b0);
        b1.flush = 1'b0;
        tick();
        chk("t4_fl_done2", b1.done, 1'b0);
        chk("t4_fl_busy2", b1.busy, 1'b0);
        b1.start = 1'b1; b1.flush = 1'b1; tick();
        b1.start = 1'b0; b1.flush = 1'b0;
        chk("t4_sf_busy", b1.busy, 1'b0);
        chk("t4_sf_mux", b1.mux_reset, 4'b1111);
        tick();
        chk("t4_sf_busy2", b1.busy, 1'b0);

        // Reset mid-run at cnt=2, then a fresh single-round start
        b1.start = 1'b1; tick(); b1.start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t5_mux%0d", k), b1.mux_reset, pat[k]);
            if (k == 2) rst_n = 1'b0;
            tick();
        end
        chk("t5_rst_mux", b1.mux_reset, 4'b1111);
        chk("t5_rst_busy", b1.busy, 1'b0);
        chk("t5_rst_done", b1.done, 1'b0);
        rst_n = 1'b1;
        b1.num_rounds = 8'd1;
        b1.start = 1'b1; tick(); b1.start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t5r_mux%0d", k), b1.mux_reset, pat[k]);
            chk($sformatf("t5r_busy%0d", k), b1.busy, 1'b1);
            tick();
        end
        chk("t5r_done", b1.done, 1'b1);
        tick();

        // Two-channel instance, two rounds, ignored start during RUN
        b2.start = 1'b1; tick(); b2.start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("t6_mux%0d", k), b2.mux_reset, p2[k % 3]);
            chk($sformatf("t6_busy%0d", k), b2.busy, 1'b1);
            chk($sformatf("t6_done%0d", k), b2.done, 1'b0);
`ifdef CTRL_MUX_STREAM_STATUS_EN
            chk($sformatf("t6_round%0d", k), b2.round_idx, k / 3);
            chk($sformatf("t6_serr%0d", k), b2.start_err, (k >= 2) ? 1'b1 : 1'b0);
`endif
            b2.start = (k == 1);
            tick();
        end
        chk("t6_done", b2.done, 1'b1);
        chk("t6_done_mux", b2.mux_reset, 2'b11);
`ifdef CTRL_MUX_STREAM_STATUS_EN
        chk("t6_done_round", b2.round_idx, 8'd0);
        chk("t6_done_serr", b2.start_err, 1'b1);
`endif
        tick();
        chk("t6_idle_done", b2.done, 1'b0);
        chk("t6_idle_busy", b2.busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
